// File: rtl/lbp_pkg.sv
// Shared types and tables for the LBP engine: FSM states, 3x3 window slots,
// code bit positions and the circular neighbour order used by the uniform check.
package lbp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CALC,
        ST_WRITE,
        ST_DONE
    } lbp_state_t;

    // Window slots, row-major over the 3x3 neighbourhood.
    localparam logic [3:0] SLOT_TL = 4'd0;
    localparam logic [3:0] SLOT_T  = 4'd1;
    localparam logic [3:0] SLOT_TR = 4'd2;
    localparam logic [3:0] SLOT_L  = 4'd3;
    localparam logic [3:0] SLOT_C  = 4'd4;
    localparam logic [3:0] SLOT_R  = 4'd5;
    localparam logic [3:0] SLOT_BL = 4'd6;
    localparam logic [3:0] SLOT_B  = 4'd7;
    localparam logic [3:0] SLOT_BR = 4'd8;

    localparam int BIT_TL = 0;
    localparam int BIT_T  = 1;
    localparam int BIT_TR = 2;
    localparam int BIT_L  = 3;
    localparam int BIT_R  = 4;
    localparam int BIT_BL = 5;
    localparam int BIT_B  = 6;
    localparam int BIT_BR = 7;

    // Window slot feeding each code bit, indexed by bit position.
    localparam logic [3:0] NBR_SLOT [8] = '{SLOT_TL, SLOT_T, SLOT_TR, SLOT_L,
                                            SLOT_R, SLOT_BL, SLOT_B, SLOT_BR};

    // Code bits walked once around the ring of neighbours.
    localparam int CIRC_BITS [8] = '{BIT_TL, BIT_T, BIT_TR, BIT_R,
                                     BIT_BR, BIT_B, BIT_BL, BIT_L};

    localparam logic [3:0] FULL_READS  = 4'd9;
    localparam logic [3:0] SHIFT_READS = 4'd3;

    // Window slot targeted by the k-th read of a full or shift fetch.
    function automatic logic [3:0] fetch_slot(input logic full, input logic [3:0] k);
        logic [3:0] slot;
        slot = SLOT_BR;
        if (full) begin
            case (k)
                4'd0:    slot = SLOT_C;
                4'd1:    slot = SLOT_TL;
                4'd2:    slot = SLOT_T;
                4'd3:    slot = SLOT_TR;
                4'd4:    slot = SLOT_L;
                4'd5:    slot = SLOT_R;
                4'd6:    slot = SLOT_BL;
                4'd7:    slot = SLOT_B;
                default: slot = SLOT_BR;
            endcase
        end else begin
            case (k)
                4'd0:    slot = SLOT_TR;
                4'd1:    slot = SLOT_R;
                default: slot = SLOT_BR;
            endcase
        end
        return slot;
    endfunction

    function automatic logic [1:0] slot_row(input logic [3:0] slot);
        return 2'(slot / 4'd3);
    endfunction

    function automatic logic [1:0] slot_col(input logic [3:0] slot);
        return 2'(slot % 4'd3);
    endfunction

    // Uniform pattern: at most two 0/1 transitions around the neighbour ring.
    function automatic logic is_uniform(input logic [7:0] code);
        int trans;
        trans = 0;
        for (int i = 0; i < 8; i++) begin
            if (code[CIRC_BITS[i]] != code[CIRC_BITS[(i + 1) % 8]]) begin
                trans++;
            end
        end
        return (trans <= 2);
    endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 pixel window: indexed load, left shift by one column, and the
// neighbour >= centre comparator producing the 8-bit LBP code.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic [3:0]       load_idx,
    input  logic [PIX_W-1:0] load_data,
    output logic [7:0]       code
);

    // Contents are meaningless until a full fetch, so no reset is needed.
    logic [PIX_W-1:0] cell_reg [9];

    always_ff @(posedge clk) begin
        if (load_en) begin
            cell_reg[load_idx] <= load_data;
        end else if (shift_en) begin
            for (int r = 0; r < 3; r++) begin
                cell_reg[3*r]     <= cell_reg[3*r + 1];
                cell_reg[3*r + 1] <= cell_reg[3*r + 2];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign code[gi] = (cell_reg[NBR_SLOT[gi]] >= cell_reg[SLOT_C]);
        end
    endgenerate

endmodule

// File: rtl/lbp_engine.sv
// LBP engine: raster-scans a 2^ROW_W x 2^COL_W image, fetching pixels over a
// one-cycle-latency read port and emitting one code per pixel with a ready handshake.
// Optional LBP_UNIFORM_EN adds the registered lbp_uniform flag.
module lbp_engine
    import lbp_pkg::*;
#(
    parameter int COL_W = 7,
    parameter int ROW_W = 7,
    parameter int PIX_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gray_ready,
    output logic                   gray_req,
    output logic [ROW_W+COL_W-1:0] gray_addr,
    input  logic [PIX_W-1:0]       gray_data,
    output logic [ROW_W+COL_W-1:0] lbp_addr,
    output logic [7:0]             lbp_data,
    output logic                   lbp_valid,
    input  logic                   lbp_ready,
`ifdef LBP_UNIFORM_EN
    output logic                   lbp_uniform,
`endif
    output logic                   finish
);

    localparam logic [ROW_W-1:0] ROW_MAX = '1;
    localparam logic [COL_W-1:0] COL_MAX = '1;

    lbp_state_t       state_reg, state_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             full_reg, full_next;
    logic [7:0]       lbp_data_reg, lbp_data_next;

    logic             win_shift;
    logic             win_load;
    logic [3:0]       win_load_idx;
    logic [7:0]       win_code;

    logic             last_col;
    logic             last_row;
    logic [ROW_W-1:0] adv_row;
    logic [COL_W-1:0] adv_col;
    logic             adv_border;
    logic [3:0]       n_reads;
    logic             issue;
    logic [3:0]       rd_slot;
    logic [ROW_W-1:0] rd_row;
    logic [COL_W-1:0] rd_col;

    // Raster successor of the current pixel and whether it needs any reads.
    assign last_col   = (col_reg == COL_MAX);
    assign last_row   = (row_reg == ROW_MAX);
    assign adv_row    = last_col ? (row_reg + ROW_W'(1)) : row_reg;
    assign adv_col    = last_col ? '0 : (col_reg + COL_W'(1));
    assign adv_border = (adv_row == '0) || (adv_row == ROW_MAX) ||
                        (adv_col == '0) || (adv_col == COL_MAX);

    // Read sequencer: issue on cnt 0..n-1, capture the previous read on cnt 1..n.
    assign n_reads      = full_reg ? FULL_READS : SHIFT_READS;
    assign issue        = (state_reg == ST_FETCH) && (cnt_reg < n_reads);
    assign rd_slot      = fetch_slot(full_reg, cnt_reg);
    assign rd_row       = row_reg + ROW_W'(slot_row(rd_slot)) - ROW_W'(1);
    assign rd_col       = col_reg + COL_W'(slot_col(rd_slot)) - COL_W'(1);
    assign win_load_idx = fetch_slot(full_reg, cnt_reg - 4'd1);

    assign gray_req  = issue;
    assign gray_addr = issue ? {rd_row, rd_col} : '0;

    lbp_window #(
        .PIX_W (PIX_W)
    ) u_window (
        .clk       (clk),
        .shift_en  (win_shift),
        .load_en   (win_load),
        .load_idx  (win_load_idx),
        .load_data (gray_data),
        .code      (win_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            cnt_reg      <= '0;
            full_reg     <= 1'b0;
            lbp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            cnt_reg      <= cnt_next;
            full_reg     <= full_next;
            lbp_data_reg <= lbp_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        cnt_next      = cnt_reg;
        full_next     = full_reg;
        lbp_data_next = lbp_data_reg;
        win_shift     = 1'b0;
        win_load      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Pixel (0,0) is always a border pixel.
                if (gray_ready) begin
                    state_next    = ST_WRITE;
                    lbp_data_next = '0;
                end
            end
            ST_FETCH: begin
                win_load = (cnt_reg != 4'd0);
                if (cnt_reg == n_reads) begin
                    state_next = ST_CALC;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_CALC: begin
                lbp_data_next = win_code;
                state_next    = ST_WRITE;
            end
            ST_WRITE: begin
                if (lbp_ready) begin
                    if (last_row && last_col) begin
                        state_next = ST_DONE;
                    end else begin
                        row_next = adv_row;
                        col_next = adv_col;
                        if (adv_border) begin
                            state_next    = ST_WRITE;
                            lbp_data_next = '0;
                        end else begin
                            // Column 1 starts a fresh window; later columns reuse two thirds of it.
                            state_next = ST_FETCH;
                            cnt_next   = '0;
                            full_next  = (adv_col == COL_W'(1));
                            win_shift  = (adv_col != COL_W'(1));
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign lbp_valid = (state_reg == ST_WRITE);
    assign lbp_addr  = {row_reg, col_reg};
    assign lbp_data  = lbp_data_reg;
    assign finish    = (state_reg == ST_DONE);

`ifdef LBP_UNIFORM_EN
    logic uniform_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            uniform_reg <= 1'b0;
        end else begin
            uniform_reg <= is_uniform(lbp_data_next);
        end
    end

    assign lbp_uniform = uniform_reg;
`endif

endmodule
